// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store path (A)
// and a secondary requester (B). One access is in flight at a time; on a
// conflict the port that was not granted last wins.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          ack_a,
  output logic [DW-1:0] rdata_a,
  output logic          stall_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_b,
  output logic [DW-1:0] rdata_b,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // state | meaning
  // IDLE  | no access in flight, waiting for a request
  // ISSUE | memory strobe driven from the latched request
  // RESP  | registered read data returned, ack pulsed to owner
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state, state_nxt;
  logic          owner, owner_nxt;   // 0 = port A, 1 = port B
  logic          last, last_nxt;
  logic          lat_we, lat_we_nxt;
  logic [AW-1:0] lat_addr, lat_addr_nxt;
  logic [DW-1:0] lat_wdata, lat_wdata_nxt;
  logic          grant;
  logic          grant_port;

  // State and request latch registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      last      <= last_nxt;
      lat_we    <= lat_we_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_wdata <= lat_wdata_nxt;
    end
  end

  // Next-state, grant selection and request latching
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    last_nxt      = last;
    lat_we_nxt    = lat_we;
    lat_addr_nxt  = lat_addr;
    lat_wdata_nxt = lat_wdata;
    grant         = 1'b0;
    grant_port    = owner;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          grant = 1'b1;
          if (req_a && req_b) grant_port = ~last;
          else                grant_port = req_b;
        end
      end
      ISSUE: state_nxt = RESP;
      RESP: begin
        // the owner's own req is ignored here; it drops after its ack
        if (owner ? req_a : req_b) begin
          grant      = 1'b1;
          grant_port = ~owner;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (grant) begin
      state_nxt     = ISSUE;
      owner_nxt     = grant_port;
      last_nxt      = grant_port;
      lat_we_nxt    = grant_port ? we_b    : we_a;
      lat_addr_nxt  = grant_port ? addr_b  : addr_a;
      lat_wdata_nxt = grant_port ? wdata_b : wdata_a;
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en & lat_we;
  assign mem_addr  = mem_en ? lat_addr  : '0;
  assign mem_wdata = mem_en ? lat_wdata : '0;

  assign ack_a   = (state == RESP) & ~owner;
  assign ack_b   = (state == RESP) &  owner;
  assign rdata_a = (ack_a & ~lat_we) ? mem_rdata : '0;
  assign rdata_b = (ack_b & ~lat_we) ? mem_rdata : '0;

  assign stall_a = reset & req_a & ~ack_a;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter with a transaction-timing reference model.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [31:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0;
  logic        ack_a, ack_b, stall_a, mem_en, mem_we, busy;
  logic [31:0] rdata_a, rdata_b, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .rdata_a(rdata_a), .stall_a(stall_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .rdata_b(rdata_b),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Registered single-port memory seen by the arbiter
  logic [31:0] ram [256];
  logic [31:0] ram_q = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
      else        ram_q <= ram[mem_addr[9:2]];
    end
  end
  assign mem_rdata = ram_q;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: accesses are serialized; a grant at edge g gives the
  // strobe in cycle g..g+1 and the ack in g+1..g+2. At edge g+2 only the
  // other port may be granted; from edge g+3 on anyone may, ties going to
  // the port not granted last.
  logic [31:0] ref_mem [256];
  int          e = 0;
  int          g_edge = -100;
  bit          own = 1'b0, last_p = 1'b1;
  bit          f_we = 1'b0;
  logic [31:0] f_addr = '0, f_wdata = '0, f_rd = '0;
  bit          done_a, done_b;
  int          p_req = 100;
  int          na = 0, nb = 0;
  bit          x_en, x_we, x_ack_a, x_ack_b, x_busy;
  logic [31:0] x_addr, x_wdata, x_rd_a, x_rd_b;

  task automatic exp_update();
    int d;
    d = e - g_edge;
    x_en = reset && d == 0;
    x_we = x_en && f_we;
    x_addr  = x_en ? f_addr  : 32'h0;
    x_wdata = x_en ? f_wdata : 32'h0;
    x_ack_a = reset && d == 1 && !own;
    x_ack_b = reset && d == 1 &&  own;
    x_rd_a  = x_ack_a ? f_rd : 32'h0;
    x_rd_b  = x_ack_b ? f_rd : 32'h0;
    x_busy  = reset && (d == 0 || d == 1);
  endtask

  task automatic model_edge();
    int d;
    bit g, gp;
    done_a = 1'b0;
    done_b = 1'b0;
    e++;
    if (!reset) begin
      g_edge = -100;
      last_p = 1'b1;
    end else begin
      d = e - g_edge;
      if (d == 1) begin
        if (f_we) ref_mem[f_addr[9:2]] = f_wdata;
        f_rd = f_we ? 32'h0 : ref_mem[f_addr[9:2]];
      end
      if (d == 2) begin
        if (own) done_b = 1'b1;
        else     done_a = 1'b1;
      end
      g = 1'b0;
      gp = 1'b0;
      if (d == 2) begin
        gp = ~own;
        g = gp ? req_b : req_a;
      end else if (d >= 3) begin
        if (req_a && req_b) begin gp = ~last_p; g = 1'b1; end
        else if (req_a || req_b) begin gp = req_b; g = 1'b1; end
      end
      if (g) begin
        g_edge  = e;
        own     = gp;
        last_p  = gp;
        f_we    = gp ? we_b    : we_a;
        f_addr  = gp ? addr_b  : addr_a;
        f_wdata = gp ? wdata_b : wdata_a;
      end
    end
    exp_update();
  endtask

  task automatic new_a();
    na++;
    req_a = 1'b1;
    if (na == 2) begin we_a = 1'b0; addr_a = 32'h40; end
    else begin we_a = 1'($urandom_range(1)); addr_a = {22'h0, 8'($urandom), 2'b00}; end
    wdata_a = $urandom;
  endtask

  task automatic new_b();
    nb++;
    req_b = 1'b1;
    if (nb == 1) begin we_b = 1'b1; addr_b = 32'h40; wdata_b = 32'h12345678; end
    else begin we_b = 1'($urandom_range(1)); addr_b = {22'h0, 8'($urandom), 2'b00}; wdata_b = $urandom; end
  endtask

  // Requesters hold req until ack; fields wobble while in flight
  task automatic agents();
    bit fl;
    fl = reset && (e - g_edge) <= 1;
    if (done_a) begin
      if ($urandom_range(1) == 1) new_a(); else req_a = 1'b0;
    end else if (!req_a) begin
      if (int'($urandom_range(99)) < p_req) new_a();
    end else if (fl && !own) begin
      we_a = 1'($urandom_range(1)); addr_a = $urandom; wdata_a = $urandom;
    end
    if (done_b) begin
      if ($urandom_range(1) == 1) new_b(); else req_b = 1'b0;
    end else if (!req_b) begin
      if (int'($urandom_range(99)) < p_req) new_b();
    end else if (fl && own) begin
      we_b = 1'($urandom_range(1)); addr_b = $urandom; wdata_b = $urandom;
    end
  endtask

  task automatic check_all();
    check("mem_en", 32'(mem_en), 32'(x_en));
    check("mem_we", 32'(mem_we), 32'(x_we));
    check("mem_addr", mem_addr, x_addr);
    check("mem_wdata", mem_wdata, x_wdata);
    check("ack_a", 32'(ack_a), 32'(x_ack_a));
    check("ack_b", 32'(ack_b), 32'(x_ack_b));
    check("rdata_a", rdata_a, x_rd_a);
    check("rdata_b", rdata_b, x_rd_b);
    check("stall_a", 32'(stall_a), 32'(reset & req_a & ~x_ack_a));
    check("busy", 32'(busy), 32'(x_busy));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    agents();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[64] = 32'hDEADBEEF;
    ref_mem[64] = 32'hDEADBEEF;
    reset = 1'b0;
    req_a = 1'b1; we_a = 1'b0; addr_a = 32'h100; wdata_a = 32'h0;
    na = 1;
    exp_update();
    #12;
    check_all();
    step();
    step();
    reset = 1'b1;
    exp_update();
    for (int i = 0; i < 1000; i++) step();
    p_req = 30;
    for (int i = 0; i < 1500; i++) step();
    p_req = 8;
    for (int i = 0; i < 1500; i++) step();

    // abort an access mid-strobe
    p_req = 60;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (e == g_edge) found = 1'b1;
    end
    check("find_issue", 32'(found), 32'd1);
    reset = 1'b0;
    #1;
    exp_update();
    check_all();
    step();
    step();
    reset = 1'b1;
    exp_update();
    for (int i = 0; i < 300; i++) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
